serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one instance of the existing 1-bit
//  full_adder cell plus a registered carry. On start, latches operands and
//  carry-in, then adds one bit per clock, LSB first.
//  Presents {Cout,Sum} with a one-cycle done pulse.
//  Area-cheap adder for datapaths that can tolerate WIDTH-cycle latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 1
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  A      in   WIDTH  operand A; sampled on the start edge only
//  B      in   WIDTH  operand B; sampled on the start edge only
//  Cin    in   1      carry-in; sampled on the start edge only
//  Sum    out  WIDTH  result; holds last completed result
//  Cout   out  1      carry-out of last completed result
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse; Sum/Cout valid in this cycle
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE.
//    Sum=0, Cout=0, busy=0, done=0.
//    Operand/sum shift regs, carry reg and bit counter all cleared.
//  - States: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE).
//    Both are decoded from the state register only.
//  - IDLE: start=1 at edge E0 -> a_sr<=A, b_sr<=B, c_reg<=Cin, cnt<=0, go RUN.
//    start=0 -> stay IDLE.
//  - RUN, each edge: full_adder(a_sr[0], b_sr[0], c_reg) -> fs, fc.
//    - s_sr <= {fs, s_sr[WIDTH-1:1]}; a_sr, b_sr shift right 1.
//    - c_reg <= fc; cnt <= cnt+1.
//  - RUN, last bit (cnt==WIDTH-1): Sum <= {fs, s_sr[WIDTH-1:1]}, Cout <= fc,
//    go DONE. Sum/Cout change only on this edge (and on reset).
//  - DONE: lasts exactly one cycle, then go IDLE unconditionally.
//  - Latency: start sampled at E0 -> done high between edges E0+WIDTH and
//    E0+WIDTH+1. busy is high for exactly WIDTH cycles.
//  - Max throughput: one op per WIDTH+2 cycles. start may be asserted during
//    DONE but is only accepted in the IDLE cycle that follows.
//  - start during RUN or DONE: ignored; no queuing.
//    A/B/Cin changes after E0 do not affect the result in flight.
//  - Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1); no overflow flag.
//  - Counter width: $clog2(WIDTH+1). WIDTH=1 completes in a single RUN cycle.
//  - Reset mid-RUN/DONE: operation aborted, no done pulse, Sum/Cout cleared.
//    The next start after reset release behaves normally.
// STRUCTURE
//  - Shared header serial_adder_defs.vh: 2-bit state encodings
//    (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default.
//  - Encoding 2'd3 is illegal; the FSM returns to IDLE from it.
//  - Sub-module: one full_adder instance (existing cell, ports A,B,Cin,Sum,Cout)
//    forms the per-bit datapath. No other sub-modules.
//  - Everything else is local: one FSM always block, one datapath always block.
// TESTING
//  1. Reset: rst=1 mid-sim with X-free inputs -> Sum=0, Cout=0, busy=0,
//     done=0 immediately (asynchronous), without waiting for a clk edge.
//  2. WIDTH=8, A=8'h5A, B=8'h3C, Cin=0, start 1 cycle -> Sum=8'h96, Cout=0.
//     busy high 8 cycles; done high exactly one cycle, 8 edges after start.
//  3. Carry chain: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1.
//     Then A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
//  4. Hold start=1 throughout; change A/B every cycle during RUN:
//     - result matches operands sampled at E0;
//     - exactly one done per WIDTH+2 cycles;
//     - back-to-back ops both correct.
//  5. Abort: assert rst during 4th RUN cycle of A=8'h12, B=8'h34:
//     - outputs are 0 at once and no done is seen;
//     - after release, A=8'h12, B=8'h34 gives Sum=8'h46, Cout=0.
//  6. Exhaustive WIDTH=2: all 32 (A,B,Cin) combos vs {Cout,Sum}==A+B+Cin.
//     Self-checking compare on every done pulse.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     - state_t       : 2-bit FSM encoding (IDLE=0, RUN=1, DONE=2; 3 is illegal)
//     - DEFAULT_WIDTH : default operand/result width
//     - cnt_width()   : bit counter width able to hold 0..WIDTH
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must represent 0..WIDTH, so WIDTH=1 still gets a 1-bit counter.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Existing 1-bit full adder cell; forms the per-bit datapath of serial_adder.
//   Ports:
//     A, B, Cin : addend bits and carry-in
//     Sum       : A ^ B ^ Cin
//     Cout      : majority(A, B, Cin)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : full_adder

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. On an accepted start the operands and carry-in
//   are latched, then one bit is added per clock, LSB first, through a single
//   full_adder and a registered carry. The final edge loads {Cout,Sum} and the
//   FSM spends one cycle in DONE to pulse done.
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     start : request, sampled only in IDLE
//     A, B  : operands, sampled on the accepting edge only
//     Cin   : carry-in, sampled on the accepting edge only
//     Sum   : result of last completed add (held)
//     Cout  : carry-out of last completed add (held)
//     busy  : high while in RUN (WIDTH cycles)
//     done  : one-cycle pulse, Sum/Cout valid
// ----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   s_sr_r;
    logic [WIDTH-1:0]   s_shift_s;
    logic [WIDTH-1:0]   sum_r;
    logic               c_reg_r;
    logic               cout_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               fs_s;
    logic               fc_s;
    logic               last_bit_s;

    full_adder u_full_adder (
        .A    (a_sr_r[0]),
        .B    (b_sr_r[0]),
        .Cin  (c_reg_r),
        .Sum  (fs_s),
        .Cout (fc_s)
    );

    assign last_bit_s = (cnt_r == LAST_CNT);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    // A 1-bit adder has no older bits to keep, so it needs its own form.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign s_shift_s = fs_s;
        end else begin : g_shift_wn
            assign s_shift_s = {fs_s, s_sr_r[WIDTH-1:1]};
        end
    endgenerate

    // busy/done decode straight from the state register: no combinational
    // path from start to the status outputs.
    assign busy = (state_r == ST_RUN);
    assign done = (state_r == ST_DONE);
    assign Sum  = sum_r;
    assign Cout = cout_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-bit shifting, carry and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            s_sr_r  <= '0;
            c_reg_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_r  <= A;
                        b_sr_r  <= B;
                        c_reg_r <= Cin;
                        cnt_r   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr_r  <= a_sr_r >> 1;
                    b_sr_r  <= b_sr_r >> 1;
                    s_sr_r  <= s_shift_s;
                    c_reg_r <= fc_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    // Result registers move only on the final bit.
                    if (last_bit_s) begin
                        sum_r  <= s_shift_s;
                        cout_r <= fc_s;
                    end
                end
                default: begin
                    // DONE and illegal encoding: hold all datapath state.
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Directed self-checking bench: an 8-bit instance for the main scenarios and
//   a 2-bit instance for the exhaustive sweep. Outputs are sampled on the
//   falling clock edge; inputs are driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] Sum;
    logic       Cout;
    logic       busy;
    logic       done;

    logic       start2;
    logic [1:0] A2;
    logic [1:0] B2;
    logic       Cin2;
    logic [1:0] Sum2;
    logic       Cout2;
    logic       busy2;
    logic       done2;

    int checks;
    int errors;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .A     (A2),
        .B     (B2),
        .Cin   (Cin2),
        .Sum   (Sum2),
        .Cout  (Cout2),
        .busy  (busy2),
        .done  (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one op on the 8-bit DUT, scramble the inputs right after the
    // accepting edge, and observe 12 cycles. k counts edges after E0.
    task automatic apply_op(input logic [7:0] a, input logic [7:0] b,
                            input logic cin,
                            output logic [7:0] s, output logic c,
                            output int busy_n, output int done_n,
                            output int done_k);
        busy_n = 0;
        done_n = 0;
        done_k = -1;
        s      = 8'h00;
        c      = 1'b0;
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; A = ~a; B = ~b; Cin = ~cin;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_k = k;
                s = Sum;
                c = Cout;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        start2 = 1'b0; A2 = 2'b00; B2 = 2'b00; Cin2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({Sum, Cout, busy, done} !== 11'h000) begin
            errors++;
            $display("FAIL reset_state: got Sum=%h Cout=%b busy=%b done=%b, want all 0",
                     Sum, Cout, busy, done);
        end
        checks++;
        if ({Sum2, Cout2, busy2, done2} !== 5'h00) begin
            errors++;
            $display("FAIL reset_state_w2: got Sum=%h Cout=%b busy=%b done=%b, want all 0",
                     Sum2, Cout2, busy2, done2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic c; int bn; int dn; int dk;
        apply_op(8'h5A, 8'h3C, 1'b0, s, c, bn, dn, dk);
        checks++;
        if ({c, s} !== 9'h096) begin
            errors++;
            $display("FAIL basic_sum: got {Cout,Sum}=%h, want 096", {c, s});
        end
        checks++;
        if (bn !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
        end
        checks++;
        if (dn !== 1 || dk !== 8) begin
            errors++;
            $display("FAIL basic_done_pulse: got count=%0d at edge %0d, want 1 at 8", dn, dk);
        end
        checks++;
        if ({Cout, Sum} !== 9'h096) begin
            errors++;
            $display("FAIL basic_hold: got {Cout,Sum}=%h, want 096", {Cout, Sum});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({Sum, Cout, busy, done} !== 11'h000) begin
            errors++;
            $display("FAIL async_reset: got Sum=%h Cout=%b busy=%b done=%b, want all 0",
                     Sum, Cout, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_carry();
        logic [7:0] s; logic c; int bn; int dn; int dk;
        apply_op(8'hFF, 8'h01, 1'b0, s, c, bn, dn, dk);
        checks++;
        if ({c, s} !== 9'h100 || dn !== 1) begin
            errors++;
            $display("FAIL carry_ff_01: got {Cout,Sum}=%h dones=%0d, want 100 and 1", {c, s}, dn);
        end
        apply_op(8'hFF, 8'hFF, 1'b1, s, c, bn, dn, dk);
        checks++;
        if ({c, s} !== 9'h1FF || dn !== 1) begin
            errors++;
            $display("FAIL carry_ff_ff_1: got {Cout,Sum}=%h dones=%0d, want 1FF and 1", {c, s}, dn);
        end
    endtask

    // start held high, operands changing every cycle: ops accepted at
    // E0 and E0+10, done pulses after edges 8 and 18.
    task automatic test_back_to_back();
        int         dn;
        int         dk[2];
        logic [8:0] got[2];
        logic [8:0] exp0;
        logic [8:0] exp1;
        logic [7:0] a0, b0, a10, b10;
        dn = 0; dk[0] = -1; dk[1] = -1; got[0] = 9'h000; got[1] = 9'h000;
        a0  = 8'h05;                     b0  = 8'h07;
        a10 = 8'(10 * 8'h13 + 8'h05);    b10 = 8'(10 * 8'h29 + 8'h07);
        exp0 = 9'h00D;                   // 05 + 07 + 1
        exp1 = 9'h165;                   // C3 + A1 + 1
        @(negedge clk);
        A = a0; B = b0; Cin = 1'b1; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                if (dn < 2) begin
                    dk[dn] = k;
                    got[dn] = {Cout, Sum};
                end
                dn++;
            end
            A = 8'((k + 1) * 8'h13 + 8'h05);
            B = 8'((k + 1) * 8'h29 + 8'h07);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (a10 !== 8'hC3 || b10 !== 8'hA1 || got[0] !== exp0) begin
            errors++;
            $display("FAIL b2b_first: got %h, want %h", got[0], exp0);
        end
        checks++;
        if (got[1] !== exp1) begin
            errors++;
            $display("FAIL b2b_second: got %h, want %h", got[1], exp1);
        end
        checks++;
        if (dn !== 2 || dk[0] !== 8 || dk[1] !== 18) begin
            errors++;
            $display("FAIL b2b_done_spacing: got %0d pulses at %0d,%0d, want 2 at 8,18",
                     dn, dk[0], dk[1]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] s; logic c; int bn; int dn; int dk;
        int         late_done;
        late_done = 0;
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(negedge clk);            // after E0: first RUN cycle
        start = 1'b0;
        repeat (3) @(negedge clk); // fourth RUN cycle
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({Sum, Cout, busy, done} !== 11'h000) begin
            errors++;
            $display("FAIL abort_outputs: got Sum=%h Cout=%b busy=%b done=%b, want all 0",
                     Sum, Cout, busy, done);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) late_done++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", late_done);
        end
        apply_op(8'h12, 8'h34, 1'b0, s, c, bn, dn, dk);
        checks++;
        if ({c, s} !== 9'h046 || dn !== 1) begin
            errors++;
            $display("FAIL abort_recover: got {Cout,Sum}=%h dones=%0d, want 046 and 1", {c, s}, dn);
        end
    endtask

    task automatic test_exhaustive_w2();
        logic [2:0] exp;
        logic [1:0] a, b;
        logic       ci;
        logic [4:0] idx;
        int         seen;
        for (int i = 0; i < 32; i++) begin
            idx = 5'(i);
            a = idx[1:0]; b = idx[3:2]; ci = idx[4];
            exp = 3'(a) + 3'(b) + 3'(ci);
            @(negedge clk);
            A2 = a; B2 = b; Cin2 = ci; start2 = 1'b1;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (k == 0) start2 = 1'b0;
                if (done2 && seen == 0) begin
                    seen = 1;
                    checks++;
                    if ({Cout2, Sum2} !== exp || k !== 2) begin
                        errors++;
                        $display("FAIL w2_%0d_%0d_%0d: got %h at edge %0d, want %h at 2",
                                 a, b, ci, {Cout2, Sum2}, k, exp);
                    end
                end
            end
            if (seen == 0) begin
                checks++;
                errors++;
                $display("FAIL w2_timeout_%0d: no done pulse, want {Cout,Sum}=%h", i, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_async_reset();
        test_carry();
        test_back_to_back();
        test_abort();
        test_exhaustive_w2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
